alu_issue_q: RTL and testbench

Operand issue queue that sits directly upstream of the 64-bit execute ALU. It buffers incoming operations (a, b, op, tag) behind a valid/ready handshake and issues at most one per cycle to the ALU's registered inputs. A tag pipeline is aligned with the ALU's one-cycle registered result, so writeback knows which result belongs to which tag. It also screens divide-by-zero and illegal opcodes before they reach the ALU.

---
 rtl/alu_issue_q_if.sv | 47 ++++
 rtl/alu_issue_q.sv | 160 ++++++++++++++++
 tb/tb_alu_issue_q.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_q_if.sv
// alu_issue_q_if: bundles every non-clock/reset signal of alu_issue_q.
//   slave  : the issue queue side (accepts operations, drives ALU/result/count).
//   master : the upstream/control side (offers operations, stall, flush).
// Signals:
//   in_valid/in_ready/in_a/in_b/in_op/in_tag : operation push handshake
//   stall, flush                             : issue hold, synchronous kill
//   alu_a/alu_b/alu_op/alu_valid             : registered ALU inputs
//   res_valid/res_tag/res_dz/res_ill         : result-aligned tag stage
//   count                                    : queue occupancy
interface alu_issue_q_if #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned OP_W   = 8,
    parameter int unsigned TAG_W  = 4,
    parameter int unsigned DEPTH  = 4
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    logic [OP_W-1:0]   in_op;
    logic [TAG_W-1:0]  in_tag;
    logic              stall;
    logic              flush;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [OP_W-1:0]   alu_op;
    logic              alu_valid;
    logic              res_valid;
    logic [TAG_W-1:0]  res_tag;
    logic              res_dz;
    logic              res_ill;
    logic [CNT_W-1:0]  count;

    modport master (
        output in_valid, in_a, in_b, in_op, in_tag, stall, flush,
        input  in_ready, alu_a, alu_b, alu_op, alu_valid,
        input  res_valid, res_tag, res_dz, res_ill, count
    );

    modport slave (
        input  in_valid, in_a, in_b, in_op, in_tag, stall, flush,
        output in_ready, alu_a, alu_b, alu_op, alu_valid,
        output res_valid, res_tag, res_dz, res_ill, count
    );
endinterface

// File: rtl/alu_issue_q.sv
// alu_issue_q: operand issue queue in front of the registered 64-bit ALU.
// Buffers {a, b, op, tag} in a DEPTH-entry circular FIFO, issues at most one
// operation per cycle into the ALU input registers, screens divide-by-zero and
// illegal opcodes (forcing op 0), and carries the tag one stage behind so it
// lines up with the ALU's registered result.
// Ports:
//   clk    : clock, all state on posedge
//   rst_n  : asynchronous active-low reset
//   bus_io : alu_issue_q_if.slave (push handshake, stall/flush, ALU drive,
//            result tag stage, occupancy)
module alu_issue_q #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned OP_W   = 8,
    parameter int unsigned TAG_W  = 4,
    parameter int unsigned DEPTH  = 4
) (
    input logic          clk,
    input logic          rst_n,
    alu_issue_q_if.slave bus_io
);
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned PTR_W = AW + 1;

    localparam logic [OP_W-1:0] OpNone = '0;
    localparam logic [OP_W-1:0] OpDiv  = OP_W'(8'h04);
    localparam logic [OP_W-1:0] OpMax  = OP_W'(8'h11);

    // Queue storage; no reset needed, validity is tracked by the pointers.
    logic [DATA_W-1:0] a_mem   [DEPTH];
    logic [DATA_W-1:0] b_mem   [DEPTH];
    logic [OP_W-1:0]   op_mem  [DEPTH];
    logic [TAG_W-1:0]  tag_mem [DEPTH];

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] count;

    logic [DATA_W-1:0] alu_a_q, alu_a_d;
    logic [DATA_W-1:0] alu_b_q, alu_b_d;
    logic [OP_W-1:0]   alu_op_q, alu_op_d;
    logic              alu_valid_q;

    // Stage 1 travels alongside the ALU input registers.
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
    logic             s1_dz_q, s1_dz_d;
    logic             s1_ill_q, s1_ill_d;

    logic             res_valid_q;
    logic [TAG_W-1:0] res_tag_q;
    logic             res_dz_q;
    logic             res_ill_q;

    logic              push;
    logic              issue;
    logic [AW-1:0]     rd_idx;
    logic [DATA_W-1:0] head_a;
    logic [DATA_W-1:0] head_b;
    logic [OP_W-1:0]   head_op;
    logic              head_dz;
    logic              head_ill;

    assign count  = wr_ptr_q - rd_ptr_q;
    assign rd_idx = rd_ptr_q[AW-1:0];

    assign bus_io.in_ready = (count != PTR_W'(DEPTH)) && !bus_io.flush;
    assign push            = bus_io.in_valid && bus_io.in_ready;
    assign issue           = (count != '0) && !bus_io.stall && !bus_io.flush;

    assign head_a   = a_mem[rd_idx];
    assign head_b   = b_mem[rd_idx];
    assign head_op  = op_mem[rd_idx];
    // Opcode 4 is legal, so dz and ill are mutually exclusive by construction.
    assign head_dz  = (head_op == OpDiv) && (head_b == '0);
    assign head_ill = (head_op == OpNone) || (head_op > OpMax);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        alu_op_d = alu_op_q;
        s1_tag_d = s1_tag_q;
        s1_dz_d  = s1_dz_q;
        s1_ill_d = s1_ill_q;

        if (bus_io.flush) begin
            // in_ready is low during flush, so no push can race the drain.
            rd_ptr_d = wr_ptr_q;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (issue) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
                alu_a_d  = head_a;
                alu_b_d  = head_b;
                // Op 0 makes the ALU produce a zero result.
                alu_op_d = (head_dz || head_ill) ? OpNone : head_op;
                s1_tag_d = tag_mem[rd_idx];
                s1_dz_d  = head_dz;
                s1_ill_d = head_ill;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            a_mem[wr_ptr_q[AW-1:0]]   <= bus_io.in_a;
            b_mem[wr_ptr_q[AW-1:0]]   <= bus_io.in_b;
            op_mem[wr_ptr_q[AW-1:0]]  <= bus_io.in_op;
            tag_mem[wr_ptr_q[AW-1:0]] <= bus_io.in_tag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            alu_valid_q <= 1'b0;
            s1_tag_q    <= '0;
            s1_dz_q     <= 1'b0;
            s1_ill_q    <= 1'b0;
            res_valid_q <= 1'b0;
            res_tag_q   <= '0;
            res_dz_q    <= 1'b0;
            res_ill_q   <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            alu_valid_q <= issue;
            s1_tag_q    <= s1_tag_d;
            s1_dz_q     <= s1_dz_d;
            s1_ill_q    <= s1_ill_d;
            // Flush kills the op currently in the ALU.
            res_valid_q <= alu_valid_q && !bus_io.flush;
            if (alu_valid_q) begin
                res_tag_q <= s1_tag_q;
                res_dz_q  <= s1_dz_q;
                res_ill_q <= s1_ill_q;
            end
        end
    end

    assign bus_io.alu_a     = alu_a_q;
    assign bus_io.alu_b     = alu_b_q;
    assign bus_io.alu_op    = alu_op_q;
    assign bus_io.alu_valid = alu_valid_q;
    assign bus_io.res_valid = res_valid_q;
    assign bus_io.res_tag   = res_tag_q;
    assign bus_io.res_dz    = res_dz_q;
    assign bus_io.res_ill   = res_ill_q;
    assign bus_io.count     = count;
endmodule

// File: tb/tb_alu_issue_q.sv
// tb_alu_issue_q: directed bench for alu_issue_q with a queue-based reference
// model compared every cycle, plus literal expectations for each scenario.
module tb_alu_issue_q;
    localparam int unsigned DEPTH = 4;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic [7:0]  op;
        logic [3:0]  tag;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    alu_issue_q_if #(.DATA_W(64), .OP_W(8), .TAG_W(4), .DEPTH(DEPTH)) bus ();

    alu_issue_q #(.DATA_W(64), .OP_W(8), .TAG_W(4), .DEPTH(DEPTH)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (bus)
    );

    always #5 clk = ~clk;

    // Reference model state: contents of the queue and the two output stages.
    ent_t        mq[$];
    logic        m_alu_valid = 1'b0;
    logic [63:0] m_alu_a = '0;
    logic [63:0] m_alu_b = '0;
    logic [7:0]  m_alu_op = '0;
    logic [3:0]  m_s1_tag = '0;
    logic        m_s1_dz = 1'b0;
    logic        m_s1_ill = 1'b0;
    logic        m_res_valid = 1'b0;
    logic [3:0]  m_res_tag = '0;
    logic        m_res_dz = 1'b0;
    logic        m_res_ill = 1'b0;

    logic [3:0]  seen[$];
    int          max_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_seq(input string name, input logic [3:0] exp[$]);
        chk({name, "_len"}, 64'(seen.size()), 64'(exp.size()));
        for (int i = 0; i < exp.size() && i < seen.size(); i++) begin
            chk(name, 64'(seen[i]), 64'(exp[i]));
        end
    endtask

    function automatic void screen(input logic [7:0] op, input logic [63:0] b,
                                   output logic [7:0] eop, output logic dz,
                                   output logic ill);
        ill = !(op inside {[8'h01:8'h11]});
        dz  = (op == 8'h04) && (b == 64'd0);
        eop = (ill || dz) ? 8'h00 : op;
    endfunction

    // Compare at negedge, then advance the model with the inputs the next
    // posedge will sample (stimulus changes only at posedge+2).
    always @(negedge clk) begin
        ent_t e;
        logic [7:0] eop;
        logic dz, ill;
        logic do_issue, do_push;
        if (!rst_n) begin
            mq.delete();
            m_alu_valid = 0; m_alu_a = '0; m_alu_b = '0; m_alu_op = '0;
            m_s1_tag = '0; m_s1_dz = 0; m_s1_ill = 0;
            m_res_valid = 0; m_res_tag = '0; m_res_dz = 0; m_res_ill = 0;
        end else begin
            chk("count", 64'(bus.count), 64'(mq.size()));
            chk("in_ready", 64'(bus.in_ready), 64'((mq.size() != DEPTH) && !bus.flush));
            chk("alu_valid", 64'(bus.alu_valid), 64'(m_alu_valid));
            if (m_alu_valid) begin
                chk("alu_a", bus.alu_a, m_alu_a);
                chk("alu_b", bus.alu_b, m_alu_b);
                chk("alu_op", 64'(bus.alu_op), 64'(m_alu_op));
            end
            chk("res_valid", 64'(bus.res_valid), 64'(m_res_valid));
            if (m_res_valid) begin
                chk("res_tag", 64'(bus.res_tag), 64'(m_res_tag));
                chk("res_dz", 64'(bus.res_dz), 64'(m_res_dz));
                chk("res_ill", 64'(bus.res_ill), 64'(m_res_ill));
            end
            if (bus.res_valid) seen.push_back(bus.res_tag);
            if (int'(bus.count) > max_cnt) max_cnt = int'(bus.count);

            if (bus.flush) begin
                mq.delete();
                m_alu_valid = 0;
                m_res_valid = 0;
            end else begin
                m_res_valid = m_alu_valid;
                if (m_alu_valid) begin
                    m_res_tag = m_s1_tag;
                    m_res_dz  = m_s1_dz;
                    m_res_ill = m_s1_ill;
                end
                do_issue = (mq.size() != 0) && !bus.stall;
                do_push  = bus.in_valid && (mq.size() != DEPTH);
                if (do_issue) begin
                    e = mq.pop_front();
                    screen(e.op, e.b, eop, dz, ill);
                    m_alu_a = e.a; m_alu_b = e.b; m_alu_op = eop;
                    m_s1_tag = e.tag; m_s1_dz = dz; m_s1_ill = ill;
                end
                m_alu_valid = do_issue;
                if (do_push) mq.push_back('{bus.in_a, bus.in_b, bus.in_op, bus.in_tag});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic v, input logic [63:0] a, input logic [63:0] b,
                         input logic [7:0] op, input logic [3:0] tag);
        bus.in_valid = v;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_op    = op;
        bus.in_tag   = tag;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] exp_q[$];
        drive(1'b0, '0, '0, 8'h00, 4'h0);
        bus.stall = 1'b0;
        bus.flush = 1'b0;

        // Reset values
        #3;
        chk("rst_count", 64'(bus.count), 0);
        chk("rst_alu_valid", 64'(bus.alu_valid), 0);
        chk("rst_alu_a", bus.alu_a, 0);
        chk("rst_res_valid", 64'(bus.res_valid), 0);
        chk("rst_res_tag", 64'(bus.res_tag), 0);
        #9 rst_n = 1'b1;
        step();
        chk("rst_in_ready", 64'(bus.in_ready), 1);

        // Single ADD: 2-cycle latency
        seen.delete();
        drive(1'b1, 64'd5, 64'd7, 8'h01, 4'd3);
        step();
        drive(1'b0, '0, '0, 8'h00, 4'h0);
        step();
        chk("add_alu_valid", 64'(bus.alu_valid), 1);
        chk("add_alu_op", 64'(bus.alu_op), 64'h01);
        chk("add_a_plus_b", bus.alu_a + bus.alu_b, 64'd12);
        step();
        chk("add_res_valid", 64'(bus.res_valid), 1);
        chk("add_res_tag", 64'(bus.res_tag), 3);
        step();

        // Stall fills the queue; release drains in order
        seen.delete();
        bus.stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 64'(i + 1), 64'(i + 2), 8'h01, 4'(i));
            #1;
            chk("stall_in_ready", 64'(bus.in_ready), 64'(i < 4));
            step();
        end
        drive(1'b0, '0, '0, 8'h00, 4'h0);
        chk("stall_count", 64'(bus.count), 4);
        chk("stall_alu_valid", 64'(bus.alu_valid), 0);
        bus.stall = 1'b0;
        repeat (6) step();
        chk("drain_count", 64'(bus.count), 0);
        exp_q = '{4'd0, 4'd1, 4'd2, 4'd3};
        chk_seq("stall_order", exp_q);

        // Divide by zero and illegal opcode screening
        seen.delete();
        drive(1'b1, 64'd9, 64'd0, 8'h04, 4'd1);
        step();
        drive(1'b1, 64'd3, 64'd4, 8'h20, 4'd2);
        step();
        drive(1'b0, '0, '0, 8'h00, 4'h0);
        chk("dz_alu_op", 64'(bus.alu_op), 0);
        chk("dz_alu_a", bus.alu_a, 9);
        step();
        chk("ill_alu_op", 64'(bus.alu_op), 0);
        chk("dz_res_tag", 64'(bus.res_tag), 1);
        chk("dz_res_dz", 64'(bus.res_dz), 1);
        chk("dz_res_ill", 64'(bus.res_ill), 0);
        step();
        chk("ill_res_tag", 64'(bus.res_tag), 2);
        chk("ill_res_ill", 64'(bus.res_ill), 1);
        chk("ill_res_dz", 64'(bus.res_dz), 0);
        step();

        // Streaming 10 ops across pointer wrap
        seen.delete();
        max_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 64'(100 + i), 64'(i), 8'h02, 4'(i));
            step();
        end
        drive(1'b0, '0, '0, 8'h00, 4'h0);
        repeat (4) step();
        exp_q = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9};
        chk_seq("stream_order", exp_q);
        chk("stream_max_count", 64'(max_cnt <= 1), 1);

        // Flush with 3 queued and 1 in the ALU
        seen.delete();
        bus.stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 64'(i), 64'(i), 8'h01, 4'(10 + i));
            step();
        end
        drive(1'b0, '0, '0, 8'h00, 4'h0);
        bus.stall = 1'b0;
        step();
        chk("pre_flush_alu_valid", 64'(bus.alu_valid), 1);
        chk("pre_flush_count", 64'(bus.count), 3);
        bus.flush = 1'b1;
        drive(1'b1, 64'd1, 64'd1, 8'h01, 4'd14);
        #1;
        chk("flush_in_ready", 64'(bus.in_ready), 0);
        step();
        bus.flush = 1'b0;
        drive(1'b0, '0, '0, 8'h00, 4'h0);
        chk("flush_count", 64'(bus.count), 0);
        chk("flush_alu_valid", 64'(bus.alu_valid), 0);
        chk("flush_res_valid", 64'(bus.res_valid), 0);
        repeat (3) step();
        exp_q = {};
        chk_seq("flush_none", exp_q);

        // Asynchronous reset mid-stream
        seen.delete();
        bus.stall = 1'b1;
        drive(1'b1, 64'd5, 64'd5, 8'h01, 4'd5);
        step();
        drive(1'b1, 64'd6, 64'd6, 8'h01, 4'd6);
        step();
        drive(1'b0, '0, '0, 8'h00, 4'h0);
        chk("pre_rst_count", 64'(bus.count), 2);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_count", 64'(bus.count), 0);
        chk("arst_alu_valid", 64'(bus.alu_valid), 0);
        chk("arst_alu_op", 64'(bus.alu_op), 0);
        chk("arst_res_valid", 64'(bus.res_valid), 0);
        chk("arst_in_ready", 64'(bus.in_ready), 1);
        bus.stall = 1'b0;
        step();
        step();
        #1 rst_n = 1'b1;
        step();
        drive(1'b1, 64'd1, 64'd2, 8'h01, 4'd7);
        step();
        drive(1'b0, '0, '0, 8'h00, 4'h0);
        repeat (4) step();
        exp_q = '{4'd7};
        chk_seq("post_rst", exp_q);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
